uart_rx_peripheral: RTL and testbench
=====================================

Name: uart_rx_peripheral

Overview:
- Serial-to-parallel UART receiver: the receive-side counterpart of the UART TX peripheral.
- Samples an asynchronous 8N1/8E1/8O1 line, checks parity and stop bit, and pushes good bytes into a first-word-fall-through (FWFT) receive FIFO.
- The core pops bytes through a MMIO-load read strobe. Error conditions are exposed as sticky flags.
- Instantiated beside the TX peripheral at top level, on the core clock.

Parameters:
- FIFO_DEPTH, 256, RX FIFO entries; power of two, ≥2.
- BAUD_DIVISOR, 6945, clock cycles per bit (20-bit); ≥4.
- PAR_EN, 1, 1 = parity bit expected after data bits.
- PAR_TYPE, 0, 0 = even, 1 = odd; ignored when PAR_EN=0.

Ports:
- i_uart_rx_clk  in  1  core clock.
- i_uart_rx_rst  in  1  reset; synchronous, active-high.
- i_uart_rx_sdata  in  1  asynchronous serial line; idles high.
- i_uart_rx_rden  in  1  pop strobe from core load to RX data address.
- i_uart_rx_clr_err  in  1  clears all sticky error flags.
- o_uart_rx_pdata  out  8  FIFO head byte; valid while o_uart_rx_empty=0.
- o_uart_rx_empty  out  1  FIFO empty.
- o_uart_rx_full  out  1  FIFO full.
- o_uart_rx_valid  out  1  one-cycle pulse when a good byte is written to the FIFO.
- o_uart_rx_busy  out  1  FSM not in IDLE.
- o_uart_rx_parity_err  out  1  sticky: parity mismatch seen.
- o_uart_rx_frame_err  out  1  sticky: stop bit sampled 0.
- o_uart_rx_overrun  out  1  sticky: good byte dropped because FIFO full.

Behaviour:

Reset:
- Applied on a clock edge with i_uart_rx_rst=1; honoured mid-frame.
- FSM=IDLE, all counters 0, FIFO pointers 0.
- Synchronizer flops = 1.
- Outputs: pdata=0x00, empty=1, full=0, valid=0, busy=0, all error flags 0.

Synchronizer:
- Two-flop chain on i_uart_rx_sdata; the FSM sees the line 2 cycles late.

Bit timing:
- 20-bit counter; bit period = BAUD_DIVISOR cycles.
- Sample point = counter value BAUD_DIVISOR/2 (floor) after each bit boundary.

FSM (LSB-first data):
- IDLE: on a synced-line 1→0 edge, clear counter → START.
- START: at mid-bit, line=0 → DATA, bit index=0. Line=1 → IDLE (glitch rejected, no flag).
- DATA: sample one bit per BAUD_DIVISOR cycles into shift register. After index 7 → PARITY if PAR_EN, else STOP.
- PARITY: sample one bit. Error = (XOR of data ^ sampled bit) != PAR_TYPE → STOP.
- STOP: at the mid-bit sample, evaluate:
  - line=0 → frame_err set.
  - else parity error → parity_err set.
  - else good byte: push (or overrun if full & no pop).
  - Return to IDLE immediately (half-bit early, for resync on back-to-back frames).
- Errored bytes are discarded, never written.

Latency:
- Byte written on the edge following the stop mid-sample.
- valid pulses that same cycle; empty falls and pdata updates in the next cycle.

FIFO:
- FWFT; pdata = mem[rd_ptr].
- Pointers are log2(FIFO_DEPTH)+1 bits; full/empty derived from the MSB compare; wrap-around is natural.
- rden while empty: ignored, pointers unchanged.
- Write while full with simultaneous rden: both happen, no overrun, full stays 1.
- Write while full without rden: byte dropped, overrun set, valid not pulsed.

Sticky flags:
- Set-dominant over i_uart_rx_clr_err in the same cycle.
- Cleared only by clr_err or reset.

busy:
- 1 in START/DATA/PARITY/STOP.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each sample (start, data, parity, stop) is the 2-of-3 majority of the synced line at mid-1, mid, mid+1. The decision is taken at mid+1, so write latency grows by 1 cycle.
- Undefined: single sample at mid; no extra latency.

Test Plan:
1. BAUD_DIVISOR=16, PAR_EN=1, even parity; send 0xA5 (parity bit 0) → valid pulse once, empty falls, pdata=0xA5, no flags; rden pulse → empty=1.
2. Send 0x3C with parity bit 1 → no write, parity_err=1, empty stays 1; clr_err pulse → parity_err=0.
3. Send 0x81 with stop bit forced 0 → frame_err=1, byte discarded; next frame 0x55 received correctly as 0x55.
4. Line low pulse of 4 cycles (< BAUD_DIVISOR/2) → FSM back to IDLE, busy drops, no flags, FIFO unchanged.
5. FIFO_DEPTH=4: send 0x01..0x05 with no reads → full=1 after 4 bytes, overrun=1, reads return 0x01,0x02,0x03,0x04, then empty=1. Repeat with rden asserted on the 5th write cycle → no overrun, 0x05 retained.
6. Assert reset in the DATA state of frame 0x77 → all outputs at reset values next cycle; following frame 0x12 received as 0x12. With UART_RX_MAJORITY_EN, a 1-cycle glitch at the mid-sample of bit 3 still yields the correct byte.

Source files
------------

// File: rtl/uart_rx_peripheral.sv
// uart_rx_peripheral
//   UART receiver for 8N1 / 8E1 / 8O1 framing on the core clock. The serial line
//   is synchronised and sampled at mid-bit. Parity and the stop bit are checked.
//   Good bytes are pushed into a first-word-fall-through RX FIFO that the core
//   pops with a read strobe. Error conditions are kept as sticky flags.
//
//   Ports
//     i_uart_rx_clk        core clock
//     i_uart_rx_rst        synchronous active-high reset
//     i_uart_rx_sdata      asynchronous serial line (idles high)
//     i_uart_rx_rden       pop strobe for the FIFO head
//     i_uart_rx_clr_err    clears all sticky error flags
//     o_uart_rx_pdata      FIFO head byte, meaningful while o_uart_rx_empty=0
//     o_uart_rx_empty      FIFO empty
//     o_uart_rx_full       FIFO full
//     o_uart_rx_valid      one-cycle pulse per byte written into the FIFO
//     o_uart_rx_busy       receiver is inside a frame
//     o_uart_rx_parity_err sticky parity mismatch
//     o_uart_rx_frame_err  sticky stop-bit-low
//     o_uart_rx_overrun    sticky good byte dropped on a full FIFO
//
//   Optional build macro UART_RX_MAJORITY_EN
//     Each bit decision becomes the 2-of-3 majority of the line at mid-1, mid
//     and mid+1. The decision is taken at mid+1, which adds one cycle of latency.
module uart_rx_peripheral #(
  parameter int unsigned FIFO_DEPTH   = 256,
  parameter int unsigned BAUD_DIVISOR = 6945,
  parameter bit          PAR_EN       = 1'b1,
  parameter bit          PAR_TYPE     = 1'b0
) (
  input  logic       i_uart_rx_clk,
  input  logic       i_uart_rx_rst,
  input  logic       i_uart_rx_sdata,
  input  logic       i_uart_rx_rden,
  input  logic       i_uart_rx_clr_err,
  output logic [7:0] o_uart_rx_pdata,
  output logic       o_uart_rx_empty,
  output logic       o_uart_rx_full,
  output logic       o_uart_rx_valid,
  output logic       o_uart_rx_busy,
  output logic       o_uart_rx_parity_err,
  output logic       o_uart_rx_frame_err,
  output logic       o_uart_rx_overrun
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [19:0] BAUD_LAST = 20'(BAUD_DIVISOR - 1);
  localparam logic [19:0] MID       = 20'(BAUD_DIVISOR / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state;
  logic [19:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        par_bad;

  logic        sync_p0, sync_p1, line_p2;

  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [FIFO_DEPTH];

  logic        vld_p0;
  logic        empty_q, full_q;
  logic [7:0]  pdata_q;
  logic        parity_err_q, frame_err_q, overrun_q;

  logic        samp_bit, at_samp;
  logic        fifo_empty, fifo_full, pop;
  logic        stop_samp, good_byte, wr_fire;

  // Stage p0/p1: two-flop synchroniser. Stage p2: one-cycle history for the
  // idle falling-edge detect and the majority window.
  always_ff @(posedge i_uart_rx_clk) begin
    if (i_uart_rx_rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      line_p2 <= 1'b1;
    end else begin
      sync_p0 <= i_uart_rx_sdata;
      sync_p1 <= sync_p0;
      line_p2 <= sync_p1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [19:0] SAMP_PT = MID + 20'd1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Stage p3: oldest tap of the majority window.
  logic line_p3;
  always_ff @(posedge i_uart_rx_clk) begin
    if (i_uart_rx_rst) line_p3 <= 1'b1;
    else               line_p3 <= line_p2;
  end

  // At cnt == MID+1, the taps hold the line at mid+1, mid and mid-1.
  assign samp_bit = maj3(sync_p1, line_p2, line_p3);
`else
  localparam logic [19:0] SAMP_PT = MID;

  assign samp_bit = sync_p1;
`endif

  assign at_samp    = (state != IDLE) && (cnt == SAMP_PT);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = i_uart_rx_rden && !fifo_empty;
  assign stop_samp  = (state == STOP) && at_samp;
  assign good_byte  = stop_samp && samp_bit && !par_bad;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign wr_fire    = good_byte && (!fifo_full || pop);

  always_ff @(posedge i_uart_rx_clk) begin
    if (i_uart_rx_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      par_bad      <= 1'b0;
      vld_p0       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      pdata_q      <= 8'h00;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      vld_p0 <= wr_fire;

      // Counter wraps at each bit boundary and is parked at 0 while idle.
      if (state == IDLE || cnt == BAUD_LAST) cnt <= '0;
      else                                   cnt <= cnt + 20'd1;

      case (state)
        IDLE: begin
          if (line_p2 && !sync_p1) state <= START;
        end
        START: begin
          if (at_samp) begin
            if (!samp_bit) begin
              state   <= DATA;
              bit_idx <= '0;
              par_bad <= 1'b0;
            end else begin
              state   <= IDLE;
            end
          end
        end
        DATA: begin
          if (at_samp) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PAR_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (at_samp) begin
            par_bad <= (((^shreg) ^ samp_bit) != PAR_TYPE);
            state   <= STOP;
          end
        end
        STOP: begin
          // Leave half a bit early so a back-to-back start edge is not missed.
          if (at_samp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (wr_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);

      // Status and head byte are registered from the current pointers, so they
      // trail a write or pop by one cycle.
      empty_q <= fifo_empty;
      full_q  <= fifo_full;
      pdata_q <= fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

      if (stop_samp && !samp_bit)              frame_err_q  <= 1'b1;
      else if (i_uart_rx_clr_err)              frame_err_q  <= 1'b0;
      if (stop_samp && samp_bit && par_bad)    parity_err_q <= 1'b1;
      else if (i_uart_rx_clr_err)              parity_err_q <= 1'b0;
      if (good_byte && !wr_fire)               overrun_q    <= 1'b1;
      else if (i_uart_rx_clr_err)              overrun_q    <= 1'b0;
    end
  end

  always_ff @(posedge i_uart_rx_clk) begin
    if (state == DATA && at_samp) shreg <= {samp_bit, shreg[7:1]};
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  assign o_uart_rx_pdata      = pdata_q;
  assign o_uart_rx_empty      = empty_q;
  assign o_uart_rx_full       = full_q;
  assign o_uart_rx_valid      = vld_p0;
  assign o_uart_rx_busy       = (state != IDLE);
  assign o_uart_rx_parity_err = parity_err_q;
  assign o_uart_rx_frame_err  = frame_err_q;
  assign o_uart_rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_peripheral.sv
module tb_uart_rx_peripheral;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sdata = 1'b1;
  logic       rden = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] pdata;
  logic       empty, full, valid, busy, parity_err, frame_err, overrun;

  int tests = 0;
  int fails = 0;

  // Cycle index (posedge after frame start) at which the stop-bit decision is
  // made, i.e. the cycle in which a simultaneous pop must be presented.
`ifdef UART_RX_MAJORITY_EN
  localparam int WR_AT = 172;
`else
  localparam int WR_AT = 171;
`endif

  uart_rx_peripheral #(
    .FIFO_DEPTH  (4),
    .BAUD_DIVISOR(16),
    .PAR_EN      (1'b1),
    .PAR_TYPE    (1'b0)
  ) dut (
    .i_uart_rx_clk       (clk),
    .i_uart_rx_rst       (rst),
    .i_uart_rx_sdata     (sdata),
    .i_uart_rx_rden      (rden),
    .i_uart_rx_clr_err   (clr_err),
    .o_uart_rx_pdata     (pdata),
    .o_uart_rx_empty     (empty),
    .o_uart_rx_full      (full),
    .o_uart_rx_valid     (valid),
    .o_uart_rx_busy      (busy),
    .o_uart_rx_parity_err(parity_err),
    .o_uart_rx_frame_err (frame_err),
    .o_uart_rx_overrun   (overrun)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   vcount = 0;
  int   valid_cyc = -1;
  int   efall_cyc = -1;
  logic empty_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount++;
      valid_cyc = cyc;
    end
    if (empty_prev === 1'b1 && empty === 1'b0) efall_cyc = cyc;
    empty_prev = empty;
  end

  // One 11-bit frame, 16 cycles per bit; optional pop and one-cycle glitch at
  // a given cycle index within the frame (-1 = none).
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int rd_at, input int glitch_at);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 176; i++) begin
      sdata = bits[i/16] ^ (i == glitch_at);
      rden  = (i == rd_at);
      @(posedge clk); #1;
    end
    sdata = 1'b1;
    rden  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    rden = 1'b1;
    @(posedge clk); #1;
    rden = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (pdata !== 8'h00) begin fails++; $display("FAIL reset_pdata: got %h want 00", pdata); end
    tests++; if ({empty, full, valid, busy} !== 4'b1000) begin fails++; $display("FAIL reset_status: got %b want 1000", {empty, full, valid, busy}); end
    tests++; if ({parity_err, frame_err, overrun} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {parity_err, frame_err, overrun}); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int v0;
    v0 = vcount;
    send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
    tests++; if (vcount - v0 != 1) begin fails++; $display("FAIL basic_valid_count: got %0d want 1", vcount - v0); end
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL basic_empty: got %b want 0", empty); end
    tests++; if (pdata !== 8'hA5) begin fails++; $display("FAIL basic_pdata: got %h want a5", pdata); end
    tests++; if ({parity_err, frame_err, overrun} !== 3'b000) begin fails++; $display("FAIL basic_flags: got %b want 000", {parity_err, frame_err, overrun}); end
    tests++; if (efall_cyc != valid_cyc + 1) begin fails++; $display("FAIL basic_latency: empty fell at %0d want %0d", efall_cyc, valid_cyc + 1); end
    pop_one();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL basic_pop_empty: got %b want 1", empty); end
  endtask

  task automatic test_parity();
    int v0;
    v0 = vcount;
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
    tests++; if (vcount - v0 != 0) begin fails++; $display("FAIL parity_valid_count: got %0d want 0", vcount - v0); end
    tests++; if ({parity_err, frame_err} !== 2'b10) begin fails++; $display("FAIL parity_flags: got %b want 10", {parity_err, frame_err}); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL parity_empty: got %b want 1", empty); end
    pulse_clr();
    tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL parity_clear: got %b want 0", parity_err); end
  endtask

  task automatic test_frame();
    send_frame(8'h81, 1'b0, 1'b0, -1, -1);
    tests++; if ({frame_err, parity_err} !== 2'b10) begin fails++; $display("FAIL frame_flags: got %b want 10", {frame_err, parity_err}); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL frame_discard: empty got %b want 1", empty); end
    send_frame(8'h55, 1'b0, 1'b1, -1, -1);
    tests++; if (pdata !== 8'h55 || empty !== 1'b0) begin fails++; $display("FAIL frame_next_byte: got %h empty %b want 55 empty 0", pdata, empty); end
    pop_one();
    pulse_clr();
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL frame_clear: got %b want 0", frame_err); end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = vcount;
    @(posedge clk); #1;
    sdata = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    sdata = 1'b1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
    repeat (20) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_drop: got %b want 0", busy); end
    tests++; if ({parity_err, frame_err, overrun, empty} !== 4'b0001) begin fails++; $display("FAIL glitch_state: got %b want 0001", {parity_err, frame_err, overrun, empty}); end
    tests++; if (vcount - v0 != 0) begin fails++; $display("FAIL glitch_valid_count: got %0d want 0", vcount - v0); end
  endtask

  task automatic test_fifo_full();
    logic [4:0] par5;
    logic [7:0] exp;
    int v0;
    par5 = 5'b01011;
    v0 = vcount;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'(i + 1), par5[i], 1'b1, -1, -1);
      if (i == 2) begin
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL fifo_not_full_3: got %b want 0", full); end
      end
      if (i == 3) begin
        tests++; if (full !== 1'b1 || overrun !== 1'b0) begin fails++; $display("FAIL fifo_full_4: full %b overrun %b want 1 0", full, overrun); end
      end
    end
    tests++; if (overrun !== 1'b1 || full !== 1'b1) begin fails++; $display("FAIL fifo_overrun: overrun %b full %b want 1 1", overrun, full); end
    tests++; if (vcount - v0 != 4) begin fails++; $display("FAIL fifo_valid_count: got %0d want 4", vcount - v0); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'(i + 1);
      tests++; if (pdata !== exp) begin fails++; $display("FAIL fifo_read_%0d: got %h want %h", i, pdata, exp); end
      pop_one();
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fifo_drained: empty got %b want 1", empty); end
    pulse_clr();

    v0 = vcount;
    for (int i = 0; i < 5; i++)
      send_frame(8'(i + 1), par5[i], 1'b1, (i == 4) ? WR_AT : -1, -1);
    tests++; if (overrun !== 1'b0 || full !== 1'b1) begin fails++; $display("FAIL fifo_pop_on_write: overrun %b full %b want 0 1", overrun, full); end
    tests++; if (vcount - v0 != 5) begin fails++; $display("FAIL fifo_pop_valid_count: got %0d want 5", vcount - v0); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'(i + 2);
      tests++; if (pdata !== exp) begin fails++; $display("FAIL fifo_read2_%0d: got %h want %h", i, pdata, exp); end
      pop_one();
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fifo_drained2: empty got %b want 1", empty); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    send_frame(8'h66, 1'b0, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
    tests++; if (empty !== 1'b0 || parity_err !== 1'b1) begin fails++; $display("FAIL rstmid_setup: empty %b perr %b want 0 1", empty, parity_err); end
    d = 8'h77;
    @(posedge clk); #1;
    sdata = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    for (int b = 0; b < 3; b++) begin
      sdata = d[b];
      repeat (16) @(posedge clk);
      #1;
    end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_in_frame: busy got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if ({empty, full, valid, busy} !== 4'b1000) begin fails++; $display("FAIL rstmid_status: got %b want 1000", {empty, full, valid, busy}); end
    tests++; if (pdata !== 8'h00 || {parity_err, frame_err, overrun} !== 3'b000) begin fails++; $display("FAIL rstmid_data_flags: pdata %h flags %b want 00 000", pdata, {parity_err, frame_err, overrun}); end
    sdata = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_frame(8'h12, 1'b0, 1'b1, -1, -1);
    tests++; if (pdata !== 8'h12 || empty !== 1'b0) begin fails++; $display("FAIL rstmid_next_byte: got %h empty %b want 12 empty 0", pdata, empty); end
    pop_one();
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    send_frame(8'h5A, 1'b0, 1'b1, -1, 16 * 4 + 9);
    tests++; if (pdata !== 8'h5A || parity_err !== 1'b0) begin fails++; $display("FAIL majority_glitch: got %h perr %b want 5a 0", pdata, parity_err); end
    pop_one();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame();
    test_glitch();
    test_fifo_full();
    test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
